multi_mode_counter: RTL and testbench
=====================================

MULTI_MODE_COUNTER -- requirements
Module: multi_mode_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (legal 2..32).
REQ-002 The block SHALL have parameter EVT_WIDTH, default 8, width of the event counter.
REQ-003 The block SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port en  input  1  count enable (one step per enabled cycle).
REQ-006 The block SHALL have port load  input  1  synchronous load strobe.
REQ-007 The block SHALL have port load_val  input  WIDTH  value loaded when load=1.
REQ-008 The block SHALL have port mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold.
REQ-009 The block SHALL have port sat  input  1  1 = saturate at boundary, 0 = wrap (ignored in ping-pong).
REQ-010 The block SHALL have port limit  input  WIDTH  upper bound; legal count range 0..limit.
REQ-011 The block SHALL have port count  output  WIDTH  current count, registered.
REQ-012 The block SHALL have port dir  output  1  0 = counting up, 1 = counting down, registered.
REQ-013 The block SHALL have port tc  output  1  terminal-count pulse, registered.
REQ-014 The block SHALL have port events  output  EVT_WIDTH  number of boundary events, saturating.

Function
REQ-015 Priority per cycle SHALL be: reset > load > (en with mode != 11) > hold.
REQ-016 On load, count SHALL become min(load_val, limit); dir, events unchanged; tc SHALL be 0 next cycle.
REQ-017 Step: mode 00 SHALL add 1 and force dir=0; mode 01 SHALL subtract 1 and force dir=1; mode 10 SHALL step by the current dir; mode 11 SHALL freeze count, dir, events.
REQ-018 When en=0, count, dir and events SHALL hold and tc SHALL be 0 next cycle.
REQ-019 Boundary: step direction up with count==limit, or step direction down with count==0, SHALL be an event.
REQ-020 Event in mode 00/01, sat=0: up SHALL wrap to 0, down SHALL wrap to limit.
REQ-021 Event in mode 00/01, sat=1: count SHALL stay at the boundary.
REQ-022 Event in mode 10: dir SHALL toggle and count SHALL move one step in the new direction (limit=0: count stays 0, dir still toggles).
REQ-023 Entering mode 10 SHALL take the current dir as the initial ping-pong state; no extra cycle.
REQ-024 tc SHALL be 1 for exactly the one cycle following an event, else 0; consecutive events give tc high continuously.
REQ-025 events SHALL increment by 1 per event and saturate at 2^EVT_WIDTH-1, never wrap.
REQ-026 If count > limit (limit lowered) on an enabled step, count SHALL become limit, no event, tc=0.
REQ-027 All arithmetic SHALL be modulo-free within WIDTH; no intermediate value outside 0..limit SHALL appear on count.
REQ-028 Outputs SHALL change only on clk rising edge or reset assertion; no combinational path input->output.

Reset
REQ-029 reset=1 SHALL immediately force count=0, dir=0, tc=0, events=0, independent of clk.
REQ-030 Reset asserted mid-count SHALL discard the pending step; first step after release SHALL apply from count=0, dir=0.
REQ-031 Reset release SHALL be synchronised externally; the block SHALL take its first step on the first rising edge with reset=0 and en=1.

Verification
REQ-032 WIDTH=8, limit=5, mode=00, sat=0, en=1 for 8 cycles from reset -> count 1,2,3,4,5,0,1,2; tc=1 only the cycle count shows 0; events=1.
REQ-033 limit=3, mode=01, sat=1, load_val=2 then en=1 for 4 cycles -> count 2,1,0,0,0; tc high two cycles; events=2.
REQ-034 limit=3, mode=10, en=1 for 8 cycles from 0 -> count 1,2,3,2,1,0,1,2; dir 0,0,0,1,1,1,0,0; events=2.
REQ-035 count=200, limit lowered to 10, mode=00, en=1 -> count 10, tc=0; next cycle count 0, tc=1.
REQ-036 load=1 and en=1 same cycle with load_val=300 (WIDTH=9, limit=255) -> count 255, no step applied; EVT_WIDTH=2 with 5 events -> events stays 3.
REQ-037 reset pulsed between clk edges while count=4 -> count=0, tc=0 immediately; counting resumes 1,2,... after release.

Source files
------------

// File: rtl/multi_mode_counter.sv
// multi_mode_counter: up / down / ping-pong / hold counter over the range 0..limit.
// Supports wrap or saturate at the boundaries, synchronous load, a registered
// terminal-count pulse and a saturating boundary-event counter.
module multi_mode_counter #(
   parameter int WIDTH     = 8,
   parameter int EVT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_val,
   input  logic [1:0]           mode,
   input  logic                 sat,
   input  logic [WIDTH-1:0]     limit,
   output logic [WIDTH-1:0]     count,
   output logic                 dir,
   output logic                 tc,
   output logic [EVT_WIDTH-1:0] events
);

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_PP   = 2'b10,
      MODE_HOLD = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0]     CNT_ONE = WIDTH'(1);
   localparam logic [EVT_WIDTH-1:0] EVT_ONE = EVT_WIDTH'(1);

   mode_e                mode_q;
   logic                 step_dn;     // direction of this cycle's step (1 = down)
   logic                 over;        // count sits above a lowered limit
   logic                 at_bound;    // step would leave 0..limit
   logic [WIDTH-1:0]     count_nx;
   logic                 dir_nx;
   logic                 tc_nx;
   logic [EVT_WIDTH-1:0] events_nx;

   assign mode_q = mode_e'(mode);

   // Step direction: fixed for up/down modes, the stored dir for ping-pong and hold.
   always_comb begin
      case (mode_q)
         MODE_UP:   step_dn = 1'b0;
         MODE_DOWN: step_dn = 1'b1;
         default:   step_dn = dir;
      endcase
   end

   assign over     = (count > limit);
   assign at_bound = step_dn ? (count == '0) : (count == limit);

   // Next-state: load beats stepping; an out-of-range count is clamped before any
   // boundary logic so count never leaves 0..limit on an enabled step.
   always_comb begin
      count_nx  = count;
      dir_nx    = dir;
      tc_nx     = 1'b0;
      events_nx = events;
      if (load) begin
         count_nx = (load_val > limit) ? limit : load_val;
      end else if (en && (mode_q != MODE_HOLD)) begin
         dir_nx = step_dn;
         if (over) begin
            count_nx = limit;
         end else if (!at_bound) begin
            count_nx = step_dn ? (count - CNT_ONE) : (count + CNT_ONE);
         end else begin
            // Boundary event
            tc_nx = 1'b1;
            if (events != '1)
               events_nx = events + EVT_ONE;
            if (mode_q == MODE_PP) begin
               // Bounce: reverse and take one step the other way (stuck at 0 when limit is 0)
               dir_nx = ~step_dn;
               if (limit != '0)
                  count_nx = step_dn ? (count + CNT_ONE) : (count - CNT_ONE);
            end else if (!sat) begin
               count_nx = step_dn ? limit : '0;
            end
         end
      end
   end

   // State registers; reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= '0;
         dir    <= 1'b0;
         tc     <= 1'b0;
         events <= '0;
      end else begin
         count  <= count_nx;
         dir    <= dir_nx;
         tc     <= tc_nx;
         events <= events_nx;
      end
   end

endmodule

// File: tb/tb_multi_mode_counter.sv
// Testbench for multi_mode_counter: directed vector table, hand-written corner
// sequences and a randomized run checked against a behavioural model.
module tb_multi_mode_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, load, sat;
   logic [1:0] mode;
   logic [8:0] lv9, lim9;

   logic [7:0] count8;  logic dir8, tc8;  logic [7:0] events8;
   logic [8:0] count9;  logic dir9, tc9;  logic [1:0] events9;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_mode_counter #(.WIDTH(8), .EVT_WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(lv9[7:0]),
      .mode(mode), .sat(sat), .limit(lim9[7:0]),
      .count(count8), .dir(dir8), .tc(tc8), .events(events8));

   multi_mode_counter #(.WIDTH(9), .EVT_WIDTH(2)) u_dut9 (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(lv9),
      .mode(mode), .sat(sat), .limit(lim9),
      .count(count9), .dir(dir9), .tc(tc9), .events(events9));

   // ---------------- behavioural reference model ----------------
   typedef struct {int cnt; int dir; bit evt;} mres_t;

   function automatic mres_t ref_step(int cnt, int dir, bit e, bit ld, int lv,
                                      int md, bit st, int lim);
      mres_t r;
      int    tgt;
      r.cnt = cnt; r.dir = dir; r.evt = 0;
      if (ld) r.cnt = (lv < lim) ? lv : lim;
      else if (e && md != 3) begin
         if (md == 0) r.dir = 0;
         else if (md == 1) r.dir = 1;
         if (cnt > lim) r.cnt = lim;
         else begin
            tgt = (r.dir == 0) ? cnt + 1 : cnt - 1;
            if (tgt >= 0 && tgt <= lim) r.cnt = tgt;
            else begin
               r.evt = 1;
               if (md == 2) begin
                  r.dir = 1 - r.dir;
                  tgt = (r.dir == 0) ? cnt + 1 : cnt - 1;
                  if (tgt >= 0 && tgt <= lim) r.cnt = tgt;
               end else if (!st) r.cnt = (r.dir == 0) ? 0 : lim;
            end
         end
      end
      return r;
   endfunction

   int    m_cnt, m_dir, m_tc, m_ev8, m_ev2;
   mres_t mr;

   always_comb mr = ref_step(m_cnt, m_dir, en, load, int'(lv9), int'(mode), sat, int'(lim9));

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt <= 0; m_dir <= 0; m_tc <= 0; m_ev8 <= 0; m_ev2 <= 0;
      end else begin
         m_cnt <= mr.cnt;
         m_dir <= mr.dir;
         m_tc  <= int'(mr.evt);
         if (mr.evt) begin
            m_ev8 <= (m_ev8 < 255) ? m_ev8 + 1 : 255;
            m_ev2 <= (m_ev2 < 3) ? m_ev2 + 1 : 3;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      en = 0; load = 0; sat = 0; mode = 2'b00; lv9 = '0; lim9 = '0;
   endtask

   // Called at a negedge: pulses reset well clear of the next rising edge.
   task automatic pulse_reset();
      reset = 1'b1;
      #2 reset = 1'b0;
   endtask

   typedef struct {
      bit rst; bit en; bit ld; int lv; int md; bit st; int lim;
      int ec; int ed; int et; int ee;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit rst, input bit e, input bit ld, input int lv, input int md,
                      input bit st, input int lim, input int ec, input int ed,
                      input int et, input int ee);
      vec_t v;
      v = '{rst, e, ld, lv, md, st, lim, ec, ed, et, ee};
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1;
      idle_inputs();

      // Vector table: {rst_before, en, load, load_val, mode, sat, limit | count, dir, tc, events}
      // up wrap, limit 5
      add(1,1,0,0,0,0,5, 1,0,0,0); add(0,1,0,0,0,0,5, 2,0,0,0);
      add(0,1,0,0,0,0,5, 3,0,0,0); add(0,1,0,0,0,0,5, 4,0,0,0);
      add(0,1,0,0,0,0,5, 5,0,0,0); add(0,1,0,0,0,0,5, 0,0,1,1);
      add(0,1,0,0,0,0,5, 1,0,0,1); add(0,1,0,0,0,0,5, 2,0,0,1);
      // ping-pong, limit 3
      add(1,1,0,0,2,0,3, 1,0,0,0); add(0,1,0,0,2,0,3, 2,0,0,0);
      add(0,1,0,0,2,0,3, 3,0,0,0); add(0,1,0,0,2,0,3, 2,1,1,1);
      add(0,1,0,0,2,0,3, 1,1,0,1); add(0,1,0,0,2,0,3, 0,1,0,1);
      add(0,1,0,0,2,0,3, 1,0,1,2); add(0,1,0,0,2,0,3, 2,0,0,2);
      // down saturate after load 2, then hold mode and en=0
      add(1,0,1,2,1,1,3, 2,0,0,0); add(0,1,0,0,1,1,3, 1,1,0,0);
      add(0,1,0,0,1,1,3, 0,1,0,0); add(0,1,0,0,1,1,3, 0,1,1,1);
      add(0,1,0,0,1,1,3, 0,1,1,2); add(0,1,0,0,3,1,3, 0,1,0,2);
      add(0,0,0,0,0,0,3, 0,1,0,2);
      // limit lowered below count
      add(1,0,1,200,0,0,255, 200,0,0,0); add(0,1,0,0,0,0,10, 10,0,0,0);
      add(0,1,0,0,0,0,10, 0,0,1,1);
      // load wins over en and clamps; then up saturate
      add(0,1,1,250,0,0,7, 7,0,0,1); add(0,1,0,0,0,1,7, 7,0,1,2);
      // ping-pong with limit 0
      add(1,1,0,0,2,0,0, 0,1,1,1); add(0,1,0,0,2,0,0, 0,0,1,2);
      // enter ping-pong while dir=1, then down wrap
      add(1,1,1,3,0,0,5, 3,0,0,0); add(0,1,0,0,1,0,5, 2,1,0,0);
      add(0,1,0,0,2,0,5, 1,1,0,0); add(0,1,0,0,2,0,5, 0,1,0,0);
      add(0,1,0,0,2,0,5, 1,0,1,1); add(0,1,1,0,1,0,5, 0,0,0,1);
      add(0,1,0,0,1,0,5, 5,1,1,2);

      // Reset state while reset is held across clock edges
      repeat (3) @(negedge clk);
      chk("reset_count", count8, 0);
      chk("reset_dir", dir8, 0);
      chk("reset_tc", tc8, 0);
      chk("reset_events", events8, 0);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) pulse_reset();
         en = tbl[i].en; load = tbl[i].ld; lv9 = 9'(tbl[i].lv);
         mode = 2'(tbl[i].md); sat = tbl[i].st; lim9 = 9'(tbl[i].lim);
         @(negedge clk);
         chk($sformatf("vec%0d_count", i), count8, tbl[i].ec);
         chk($sformatf("vec%0d_dir", i), dir8, tbl[i].ed);
         chk($sformatf("vec%0d_tc", i), tc8, tbl[i].et);
         chk($sformatf("vec%0d_events", i), events8, tbl[i].ee);
      end

      // Load 300 with en in the same cycle on the 9-bit counter: clamp to 255, no step
      idle_inputs();
      pulse_reset();
      en = 1; load = 1; lv9 = 9'd300; lim9 = 9'd255; mode = 2'b00;
      @(negedge clk);
      chk("load300_count9", count9, 255);
      chk("load300_tc9", tc9, 0);
      // Ping-pong at limit 0: first cycle clamps, then 5 events; 2-bit events saturate
      load = 0; lim9 = 9'd0; mode = 2'b10;
      repeat (6) @(negedge clk);
      chk("evtsat_events9", events9, 3);
      chk("evtsat_events8", events8, 5);
      chk("evtsat_count9", count9, 0);

      // Reset pulsed between edges while count=4
      idle_inputs();
      pulse_reset();
      en = 1; mode = 2'b00; lim9 = 9'd10;
      repeat (4) @(negedge clk);
      chk("midrst_pre_count", count8, 4);
      reset = 1'b1;
      #1;
      chk("midrst_count", count8, 0);
      chk("midrst_tc", tc8, 0);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_resume1", count8, 1);
      @(negedge clk);
      chk("midrst_resume2", count8, 2);

      // Randomized run against the model (values kept < 256 so both instances match)
      idle_inputs();
      pulse_reset();
      lim9 = 9'd6;
      for (int n = 0; n < 2000; n++) begin
         en   = ($urandom_range(0, 9) < 8);
         load = ($urandom_range(0, 19) == 0);
         mode = 2'($urandom_range(0, 3));
         sat  = 1'($urandom_range(0, 1));
         lv9  = 9'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0)
            lim9 = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 255))
                                               : 9'($urandom_range(0, 12));
         @(negedge clk);
         chk("rnd_count8", count8, m_cnt);
         chk("rnd_dir8", dir8, m_dir);
         chk("rnd_tc8", tc8, m_tc);
         chk("rnd_events8", events8, m_ev8);
         chk("rnd_count9", count9, m_cnt);
         chk("rnd_dir9", dir9, m_dir);
         chk("rnd_tc9", tc9, m_tc);
         chk("rnd_events9", events9, m_ev2);
         if ($urandom_range(0, 99) == 0) begin
            pulse_reset();
            #1;
            chk("rnd_rst_count8", count8, 0);
            chk("rnd_rst_events9", events9, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
